mcs_fpro_bridge: RTL and testbench

Registered bridge between the MicroBlaze MCS IO bus and the FPro bus inside `fpro_system`. It decodes MCS IO accesses in the bridge window and converts each one into a single-cycle FPro read or write strobe. It captures FPro read data and returns a registered `io_ready` acknowledge. Out-of-window, empty-byte-enable and protocol-violating accesses are acknowledged without touching the FPro bus and are counted in a saturating error counter.

---
 rtl/mcs_fpro_bridge.sv | 157 +++++++++++++++
 tb/tb_mcs_fpro_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs_fpro_bridge.sv
// Purpose : MicroBlaze MCS IO bus to FPro bus bridge with an error counter for rejected accesses.
// Latency : a valid access strobes FPro one cycle after the MCS strobe edge and gives io_ready one cycle later; an error access gives io_ready in the first cycle.
// Backpr.  : none. A strobe in WR/RD is dropped and counted as an error. A strobe in IDLE/ACK is always accepted.
//
// Ports:
//   clk, reset_n          - single clock, asynchronous active-low reset
//   io_*  (in)            - MCS IO bus request: strobes, address, write data, byte enables
//   io_read_data, io_ready- registered MCS response
//   fp_*  (out)           - FPro bus: chip selects, rd/wr strobes, word address, write data
//   fp_rd_data (in)       - FPro slave read data, combinational, valid while fp_rd=1
//   err_count             - saturating count of rejected/protocol-violating accesses
module mcs_fpro_bridge #(
    parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
    parameter int          ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    // MCS IO bus
    input  logic             io_addr_strobe,
    input  logic             io_read_strobe,
    input  logic             io_write_strobe,
    input  logic [31:0]      io_address,
    input  logic [31:0]      io_write_data,
    input  logic [3:0]       io_byte_enable,
    output logic [31:0]      io_read_data,
    output logic             io_ready,
    // FPro bus
    output logic             fp_mmio_cs,
    output logic             fp_video_cs,
    output logic             fp_wr,
    output logic             fp_rd,
    output logic [20:0]      fp_addr,
    output logic [31:0]      fp_wr_data,
    input  logic [31:0]      fp_rd_data,
    // status
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // Only bit 23 (space select) and the word address bits 22:2 are used
    // after acceptance, so the other address bits are not stored.
    logic [23:2]       addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ERR_W-1:0]  err_q,   err_d;
    logic              err_inc;

    // Request classification. It is only used when the bridge can accept a strobe.
    logic in_window;
    logic rd_only;
    logic wr_only;
    logic acc_wr;
    logic acc_rd;

    // Byte-lane offset bits are not used. The FPro bus is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^io_address[1:0];

    assign in_window = (io_address[31:24] == BRIDGE_BASE[31:24]);
    assign rd_only   = io_read_strobe  & ~io_write_strobe;
    assign wr_only   = io_write_strobe & ~io_read_strobe;
    // Any non-zero byte enable is a full-word write. The FPro bus has no lanes.
    assign acc_wr    = in_window & wr_only & (|io_byte_enable);
    assign acc_rd    = in_window & rd_only;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_inc = 1'b0;

        unique case (state_q)
            S_IDLE, S_ACK: begin
                // With no strobe, the bridge goes to IDLE. A strobe seen in ACK is
                // accepted as in IDLE, so back-to-back accesses have no gap.
                state_d = S_IDLE;
                if (io_addr_strobe) begin
                    addr_d  = io_address[23:2];
                    wdata_d = io_write_data;
                    if (acc_wr) begin
                        state_d = S_WR;
                    end else if (acc_rd) begin
                        state_d = S_RD;
                    end else begin
                        // Rejected access: acknowledge at once with zero data.
                        state_d = S_ACK;
                        rdata_d = 32'h0;
                        err_inc = 1'b1;
                    end
                end
            end
            S_WR: begin
                state_d = S_ACK;
                rdata_d = 32'h0;
                // A strobe here is dropped. The write in flight still completes.
                err_inc = io_addr_strobe;
            end
            S_RD: begin
                state_d = S_ACK;
                rdata_d = fp_rd_data;
                err_inc = io_addr_strobe;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The counter saturates at all-ones and does not wrap.
    always_comb begin
        err_d = err_q;
        if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs. They depend only on the state and the latched request.
    logic strobe_state;
    assign strobe_state = (state_q == S_WR) || (state_q == S_RD);

    assign fp_wr        = (state_q == S_WR);
    assign fp_rd        = (state_q == S_RD);
    assign fp_mmio_cs   = strobe_state & ~addr_q[23];
    assign fp_video_cs  = strobe_state &  addr_q[23];
    assign fp_addr      = addr_q[22:2];
    assign fp_wr_data   = wdata_q;
    assign io_ready     = (state_q == S_ACK);
    assign io_read_data = rdata_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// Purpose : scoreboard bench for mcs_fpro_bridge using directed MCS accesses.
// Latency : expected fp strobe and io_ready cycles are checked against a free-running cycle count.
// Backpr.  : not applicable. Stimulus drives one strobe per call, and the monitor checks independently.
module tb_mcs_fpro_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0] io_address, io_write_data;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        fp_mmio_cs, fp_video_cs, fp_wr, fp_rd;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data;
    logic [31:0] fp_rd_data;
    logic [7:0]  err_count;
    logic [31:0] slave_rdata;

    always #5 clk = ~clk;

    // The slave drives data only while it is strobed, so a bridge that samples
    // at the wrong time captures the filler value.
    assign fp_rd_data = fp_rd ? slave_rdata : 32'hBAD0_BAD0;

    mcs_fpro_bridge #(.BRIDGE_BASE(32'hC000_0000), .ERR_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_addr_strobe (io_addr_strobe),
        .io_read_strobe (io_read_strobe),
        .io_write_strobe(io_write_strobe),
        .io_address     (io_address),
        .io_write_data  (io_write_data),
        .io_byte_enable (io_byte_enable),
        .io_read_data   (io_read_data),
        .io_ready       (io_ready),
        .fp_mmio_cs     (fp_mmio_cs),
        .fp_video_cs    (fp_video_cs),
        .fp_wr          (fp_wr),
        .fp_rd          (fp_rd),
        .fp_addr        (fp_addr),
        .fp_wr_data     (fp_wr_data),
        .fp_rd_data     (fp_rd_data),
        .err_count      (err_count)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic [7:0]  err;
    } ack_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic        video;
        logic [20:0] addr;
        logic [31:0] wdata;
    } fp_t;

    ack_t ack_q[$];
    fp_t  fp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    logic [7:0] exp_err = 8'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string act, input string exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic check_all_zero(input string name);
        logic [119:0] all;
        all = {io_ready, io_read_data, fp_mmio_cs, fp_video_cs, fp_wr, fp_rd,
               fp_addr, fp_wr_data, err_count};
        check(all == '0, name, $sformatf("outputs=%h", all), "all zero");
    endtask

    // Monitor: whenever the DUT presents an acknowledge or FPro strobe, pop the
    // next expectation and compare.
    initial begin
        ack_t a;
        fp_t  f;
        forever begin
            @(negedge clk);
            if (io_ready) begin
                if (ack_q.size() == 0) begin
                    check(1'b0, "unexpected io_ready", $sformatf("io_ready=1 at cyc %0d", cyc), "no ack");
                end else begin
                    a = ack_q.pop_front();
                    check(cyc == a.cyc && io_read_data == a.rdata && err_count == a.err, "ack",
                          $sformatf("cyc=%0d rdata=%h err=%h", cyc, io_read_data, err_count),
                          $sformatf("cyc=%0d rdata=%h err=%h", a.cyc, a.rdata, a.err));
                end
            end
            if (fp_wr || fp_rd) begin
                if (fp_q.size() == 0) begin
                    check(1'b0, "unexpected fp strobe", $sformatf("wr=%b rd=%b at cyc %0d", fp_wr, fp_rd, cyc), "none");
                end else begin
                    f = fp_q.pop_front();
                    check(cyc == f.cyc && fp_wr == f.wr && fp_rd == !f.wr &&
                          fp_video_cs == f.video && fp_mmio_cs == !f.video &&
                          fp_addr == f.addr && (!f.wr || fp_wr_data == f.wdata), "fp strobe",
                          $sformatf("cyc=%0d wr=%b rd=%b mmio=%b vid=%b addr=%h wd=%h",
                                    cyc, fp_wr, fp_rd, fp_mmio_cs, fp_video_cs, fp_addr, fp_wr_data),
                          $sformatf("cyc=%0d wr=%b rd=%b mmio=%b vid=%b addr=%h wd=%h",
                                    f.cyc, f.wr, !f.wr, !f.video, f.video, f.addr, f.wdata));
                end
            end else if (fp_mmio_cs || fp_video_cs) begin
                check(1'b0, "cs without strobe", $sformatf("mmio=%b vid=%b", fp_mmio_cs, fp_video_cs), "0 0");
            end
        end
    end

    // Drive one MCS access starting at the current negedge. Push the expected
    // FPro strobe and acknowledge. If viol is set, the strobe is held through the
    // RD/WR cycle as a second, in-window write that must be dropped and counted.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit rd, input bit wr, input bit viol);
        bit valid;
        valid = (addr[31:24] == 8'hC0) && (rd ^ wr) && (rd || be != 4'h0);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_write_data   = wdata;
        io_byte_enable  = be;
        if (valid) begin
            fp_q.push_back('{cyc + 1, wr, addr[23], addr[22:2], wdata});
            if (viol) exp_err = sat_inc(exp_err);
            ack_q.push_back('{cyc + 2, wr ? 32'h0 : slave_rdata, exp_err});
        end else begin
            exp_err = sat_inc(exp_err);
            ack_q.push_back('{cyc + 1, 32'h0, exp_err});
        end
        @(negedge clk);
        if (viol) begin
            io_address      = 32'hC000_0100;
            io_write_data   = 32'h5555_AAAA;
            io_byte_enable  = 4'hF;
            io_read_strobe  = 1'b0;
            io_write_strobe = 1'b1;
            @(negedge clk);
        end
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = 32'h0;
        io_write_data   = 32'h0;
        io_byte_enable  = 4'h0;
        slave_rdata     = 32'h0;

        repeat (3) @(negedge clk);
        check_all_zero("reset state");

        // The first write is accepted on the first edge after release.
        reset_n = 1'b1;
        access(32'hC000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Read in video space.
        slave_rdata = 32'h1234_5678;
        access(32'hC080_0008, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Error accesses: out of window, write with be=0, both qualifiers, no qualifier.
        access(32'h8000_0000, 32'h1111_1111, 4'hF, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        access(32'hC000_0010, 32'h2222_2222, 4'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        access(32'hC000_0020, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        access(32'hC000_0024, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // A partial byte enable is a full-word write.
        access(32'hC000_0044, 32'hCAFE_F00D, 4'h3, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Back to back: a read strobe in the write's ACK cycle, then a write in the read's ACK cycle.
        access(32'hC000_0060, 32'h0BAD_CAFE, 4'hF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        slave_rdata = 32'hA5A5_0001;
        access(32'hC080_0080, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        access(32'hC07F_FFFC, 32'h7777_8888, 4'h8, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Protocol violation: a strobe during RD is dropped and counted.
        slave_rdata = 32'h600D_F00D;
        access(32'hC000_00C0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Saturation: 300 consecutive error accesses.
        for (int i = 0; i < 300; i++) begin
            if (i[0]) access(32'h8000_0000 + 32'(i * 4), 32'(i), 4'hF, 1'b0, 1'b1, 1'b0);
            else      access(32'hC000_0000 + 32'(i * 4), 32'(i), 4'h0, 1'b0, 1'b1, 1'b0);
        end
        repeat (3) @(negedge clk);
        check(err_count == 8'hFF, "err saturation", $sformatf("%h", err_count), "ff");

        // Reset asserted during the RD cycle, away from the clock edge.
        slave_rdata = 32'h0F0F_0F0F;
        access(32'hC000_0300, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset mid-RD");
        ack_q.delete();
        exp_err = 8'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        access(32'hC000_0200, 32'h0123_4567, 4'hF, 1'b0, 1'b1, 1'b0);

        // Wait for the scoreboard to drain, with a bounded wait.
        for (int k = 0; k < 20 && (ack_q.size() != 0 || fp_q.size() != 0); k++) @(negedge clk);
        check(ack_q.size() == 0 && fp_q.size() == 0, "scoreboard drain",
              $sformatf("pending ack=%0d fp=%0d", ack_q.size(), fp_q.size()), "0 pending");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
